// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_checker
// Function : Recomputes the expected ALU result for each beat, compares it with
//            the ALU output, counts pass/fail/skip and logs mismatches in a FIFO.
//            Optional macro ALU_CHECKER_HALT_ON_FAIL_EN stops intake at the
//            first mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_checker #(
    parameter int LOG_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLEAR,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [7:0]       DATA1,
    input  logic [7:0]       DATA2,
    input  logic [2:0]       SELECT,
    input  logic [7:0]       RESULT,
    output logic [CNT_W-1:0] PASS_COUNT,
    output logic [CNT_W-1:0] FAIL_COUNT,
    output logic [CNT_W-1:0] SKIP_COUNT,
    output logic             LOG_VALID,
    output logic [39:0]      LOG_DATA,
    input  logic             LOG_RD,
    output logic             LOG_OVF
);

    localparam int PTR_W = $clog2(LOG_DEPTH);
    localparam int OCC_W = PTR_W + 2;
    localparam logic [OCC_W-1:0] c_depth_occ = OCC_W'(LOG_DEPTH);
    localparam logic [PTR_W:0]   c_depth_cnt = (PTR_W + 1)'(LOG_DEPTH);

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] res;
        logic [7:0] exp;
        logic       chk;
    } beat_t;

    beat_t            s1_q, s1_d, s2_q, s2_d;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [39:0]      mem_q [LOG_DEPTH];
    logic [39:0]      mem_d [LOG_DEPTH];
    logic             ovf_q, ovf_d;

    logic             w_halt, w_accept, w_mismatch, w_pop, w_full, w_store, w_chk;
    logic [7:0]       w_exp;
    logic [OCC_W-1:0] w_occ;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef ALU_CHECKER_HALT_ON_FAIL_EN
    logic halted_q, halted_d;

    always_comb begin
        halted_d = halted_q | w_mismatch;
        if (CLEAR) halted_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) halted_q <= 1'b0;
        else        halted_q <= halted_d;
    end

    assign w_halt = halted_q;
`else
    assign w_halt = 1'b0;
`endif

    always_comb begin
        w_exp = 8'h00;
        w_chk = 1'b1;
        case (SELECT)
            3'b000:  w_exp = DATA2;
            3'b001:  w_exp = DATA1 + DATA2;
            3'b010:  w_exp = DATA1 & DATA2;
            3'b011:  w_exp = DATA1 | DATA2;
            default: w_chk = 1'b0;
        endcase
    end

    // Each in-flight beat reserves a log slot so a mismatch can never be dropped.
    assign w_occ      = OCC_W'(count_q) + OCC_W'(s1_valid_q) + OCC_W'(s2_valid_q);
    assign IN_READY   = RESET && !CLEAR && !w_halt && (w_occ < c_depth_occ);
    assign w_accept   = IN_VALID && IN_READY;
    assign w_mismatch = s2_valid_q && s2_q.chk && (s2_q.res != s2_q.exp);
    assign w_pop      = LOG_RD && (count_q != '0);
    assign w_full     = (count_q == c_depth_cnt);
    assign w_store    = w_mismatch && !(w_full && !w_pop);

    always_comb begin
        s1_valid_d = w_accept;
        s1_d.sel   = SELECT;
        s1_d.d1    = DATA1;
        s1_d.d2    = DATA2;
        s1_d.res   = RESULT;
        s1_d.exp   = w_exp;
        s1_d.chk   = w_chk;
        s2_valid_d = s1_valid_q;
        s2_d       = s1_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        skip_d     = skip_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        if (s2_valid_q) begin
            if (!s2_q.chk)       skip_d = sat_inc(skip_q);
            else if (w_mismatch) fail_d = sat_inc(fail_q);
            else                 pass_d = sat_inc(pass_q);
        end

        if (w_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (w_store) begin
            mem_d[wr_ptr_q] = {s2_q.sel, s2_q.d1, s2_q.d2, s2_q.res, s2_q.exp, 5'b0};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_mismatch && !w_store) ovf_d = 1'b1;

        case ({w_store, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (CLEAR) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            pass_d     = '0;
            fail_d     = '0;
            skip_d     = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            skip_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            skip_q     <= skip_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Payload registers carry no reset; their valids qualify them.
    always_ff @(posedge CLK) begin
        s1_q  <= s1_d;
        s2_q  <= s2_d;
        mem_q <= mem_d;
    end

    assign PASS_COUNT = pass_q;
    assign FAIL_COUNT = fail_q;
    assign SKIP_COUNT = skip_q;
    assign LOG_VALID  = (count_q != '0);
    assign LOG_DATA   = mem_q[rd_ptr_q];
    assign LOG_OVF    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_result_checker
// Function : Directed and randomized bench for alu_result_checker with an
//            in-bench behavioural model checked on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_checker;

    localparam int LOG_DEPTH = 4;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = 15;

    logic             clk = 1'b0;
    logic             RESET = 1'b0, CLEAR = 1'b0, IN_VALID = 1'b0, LOG_RD = 1'b0;
    logic [7:0]       DATA1 = '0, DATA2 = '0, RESULT = '0;
    logic [2:0]       SELECT = '0;
    logic             IN_READY, LOG_VALID, LOG_OVF;
    logic [CNT_W-1:0] PASS_COUNT, FAIL_COUNT, SKIP_COUNT;
    logic [39:0]      LOG_DATA;

    alu_result_checker #(.LOG_DEPTH(LOG_DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(clk), .RESET(RESET), .CLEAR(CLEAR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT), .RESULT(RESULT),
        .PASS_COUNT(PASS_COUNT), .FAIL_COUNT(FAIL_COUNT), .SKIP_COUNT(SKIP_COUNT),
        .LOG_VALID(LOG_VALID), .LOG_DATA(LOG_DATA), .LOG_RD(LOG_RD), .LOG_OVF(LOG_OVF)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {checked, expected}: reserved opcodes yield checked=0
    function automatic logic [8:0] ref_alu(input logic [2:0] sel, input logic [7:0] a,
                                           input logic [7:0] b);
        int s;
        case (sel)
            3'd0: return {1'b1, b};
            3'd1: begin s = (int'(a) + int'(b)) % 256; return {1'b1, 8'(s)}; end
            3'd2: return {1'b1, a & b};
            3'd3: return {1'b1, a | b};
            default: return 9'h000;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [2:0] sel;
        logic [7:0] d1, d2, res;
        int         due;
    } pend_t;

    pend_t       m_pend[$];
    logic [39:0] m_log[$];
    int          m_pass = 0, m_fail = 0, m_skip = 0, cyc = 0;
    bit          m_ovf = 0, m_halt = 0, m_on = 0;

    task automatic model_flush();
        m_pend.delete();
        m_log.delete();
        m_pass = 0; m_fail = 0; m_skip = 0;
        m_ovf = 0; m_halt = 0;
    endtask

    // Outputs compared at negedge; the model then advances across the next posedge.
    always @(negedge clk) begin
        bit          ready, pop;
        int          size_before;
        logic [8:0]  r;
        pend_t       p;
        ready = RESET && !CLEAR && !m_halt && (m_log.size() + m_pend.size() < LOG_DEPTH);
        if (m_on) begin
            check("in_ready", IN_READY, ready);
            check("pass_count", PASS_COUNT, m_pass);
            check("fail_count", FAIL_COUNT, m_fail);
            check("skip_count", SKIP_COUNT, m_skip);
            check("log_valid", LOG_VALID, m_log.size() != 0);
            check("log_ovf", LOG_OVF, m_ovf);
            if (m_log.size() != 0) check("log_data", LOG_DATA, m_log[0]);
        end
        if (!RESET) begin
            model_flush();
            m_on = 1;
        end else if (CLEAR) begin
            model_flush();
        end else begin
            size_before = m_log.size();
            pop = LOG_RD && (size_before > 0);
            if (pop) void'(m_log.pop_front());
            if (m_pend.size() > 0 && m_pend[0].due == cyc) begin
                p = m_pend.pop_front();
                r = ref_alu(p.sel, p.d1, p.d2);
                if (!r[8]) begin
                    if (m_skip < CNT_MAX) m_skip++;
                end else if (p.res == r[7:0]) begin
                    if (m_pass < CNT_MAX) m_pass++;
                end else begin
                    if (m_fail < CNT_MAX) m_fail++;
                    if (size_before == LOG_DEPTH && !pop) m_ovf = 1;
                    else m_log.push_back({p.sel, p.d1, p.d2, p.res, r[7:0], 5'b0});
`ifdef ALU_CHECKER_HALT_ON_FAIL_EN
                    m_halt = 1;
`endif
                end
            end
            if (IN_VALID && ready) begin
                p.sel = SELECT; p.d1 = DATA1; p.d2 = DATA2; p.res = RESULT; p.due = cyc + 2;
                m_pend.push_back(p);
            end
        end
        cyc++;
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                        input logic [7:0] res);
        bit got = 0;
        IN_VALID = 1'b1; DATA1 = a; DATA2 = b; SELECT = sel; RESULT = res;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = IN_READY;
            tick();
        end
        check("send_accepted", got, 1'b1);
        IN_VALID = 1'b0;
    endtask

    task automatic pulse_clear();
        IN_VALID = 1'b0;
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
    endtask

    initial begin
        logic [8:0] r;
        repeat (3) tick();
        check("ready_in_reset", IN_READY, 1'b0);
        RESET = 1'b1;
        #1;
        check("ready_after_reset", IN_READY, 1'b1);
        check("pass_after_reset", PASS_COUNT, 0);
        check("log_valid_after_reset", LOG_VALID, 1'b0);
        tick();

        // AND beats, all matching
        send(8'd25, 8'd3, 3'b010, 8'd1);
        send(8'd1, 8'd8, 3'b010, 8'd0);
        send(8'd2, 8'hFB, 3'b010, 8'd2);
        send(8'd6, 8'hFE, 3'b010, 8'd6);
        idle(2);
        check("and_pass4", PASS_COUNT, 4);
        check("and_fail0", FAIL_COUNT, 0);
        check("and_log_empty", LOG_VALID, 1'b0);

        // single AND mismatch and its log entry
        send(8'd25, 8'd3, 3'b010, 8'd3);
        idle(2);
        check("mis_fail1", FAIL_COUNT, 1);
        check("mis_log_valid", LOG_VALID, 1'b1);
        check("mis_log_data", LOG_DATA, 40'h43_2060_6020);
        LOG_RD = 1'b1;
        tick();
        LOG_RD = 1'b0;
        check("mis_popped", LOG_VALID, 1'b0);

        // ADD / OR / FORWARD / reserved
        pulse_clear();
        send(8'd100, 8'd100, 3'b001, 8'hC8);
        send(8'hF0, 8'h0F, 3'b011, 8'hFF);
        send(8'd7, 8'd9, 3'b000, 8'd9);
        send(8'd1, 8'd2, 3'b101, 8'd0);
        idle(2);
        check("ops_pass3", PASS_COUNT, 3);
        check("ops_skip1", SKIP_COUNT, 1);
        check("ops_fail0", FAIL_COUNT, 0);

        // backpressure from the mismatch log
        pulse_clear();
        for (int i = 0; i < 4; i++) send(8'd1, 8'd1, 3'b001, 8'd0);
        check("bp_ready_low", IN_READY, 1'b0);
        IN_VALID = 1'b1;
        repeat (3) tick();
        check("bp_ready_held", IN_READY, 1'b0);
        check("bp_log_valid", LOG_VALID, 1'b1);
        LOG_RD = 1'b1;
        tick();
        LOG_RD = 1'b0;
        send(8'd1, 8'd1, 3'b001, 8'd0);
        idle(2);
        check("bp_fail5", FAIL_COUNT, 5);
        check("bp_no_ovf", LOG_OVF, 1'b0);
        LOG_RD = 1'b1;
        for (int i = 0; i < 6; i++) send(8'(i), 8'd3, 3'b011, 8'd0);
        LOG_RD = 1'b0;
        idle(3);
        check("bp_no_ovf2", LOG_OVF, 1'b0);
        LOG_RD = 1'b1;
        repeat (6) tick();
        LOG_RD = 1'b0;

        // CLEAR with beats in flight; beat offered under CLEAR is refused
        send(8'd4, 8'd4, 3'b000, 8'd4);
        send(8'd5, 8'd5, 3'b000, 8'd5);
        CLEAR = 1'b1;
        IN_VALID = 1'b1;
        #1;
        check("clear_ready_low", IN_READY, 1'b0);
        tick();
        CLEAR = 1'b0;
        idle(3);
        check("clear_pass0", PASS_COUNT, 0);
        check("clear_log_empty", LOG_VALID, 1'b0);

        // RESET mid-stream
        send(8'd4, 8'd4, 3'b000, 8'd4);
        send(8'd5, 8'd5, 3'b000, 8'd0);
        RESET = 1'b0;
        IN_VALID = 1'b1;
        #1;
        check("rst_ready_low", IN_READY, 1'b0);
        tick();
        RESET = 1'b1;
        idle(3);
        check("rst_pass0", PASS_COUNT, 0);
        check("rst_fail0", FAIL_COUNT, 0);

        // counter saturation
        for (int i = 0; i < 17; i++) send(8'(i), 8'd1, 3'b010, 8'(i) & 8'd1);
        idle(2);
        check("sat_pass", PASS_COUNT, CNT_MAX);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            IN_VALID = ($urandom_range(3) != 0);
            DATA1    = 8'($urandom);
            DATA2    = 8'($urandom);
            SELECT   = 3'($urandom);
            r        = ref_alu(SELECT, DATA1, DATA2);
            RESULT   = ($urandom_range(1) == 0) ? r[7:0] : 8'($urandom);
            LOG_RD   = ($urandom_range(2) == 0);
            CLEAR    = ($urandom_range(199) == 0);
            RESET    = ($urandom_range(299) != 0);
            tick();
        end
        RESET = 1'b1; CLEAR = 1'b0; LOG_RD = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
